// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer: drives per-register bus enables and ALU handshake.
// Optional ALU wait timeout is built when REG_XFER_SEQ_ALU_TMO_EN is defined.
module reg_xfer_seq #(
  parameter int NREG    = 4,
  parameter int ALU_TMO = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [2:0]      cmd_dst,
  input  logic [2:0]      cmd_src_a,
  input  logic [2:0]      cmd_src_b,
  output logic [NREG-1:0] rdata,
  output logic [NREG-1:0] wdata,
  output logic [NREG-1:0] raddr,
  output logic [NREG-1:0] waddr,
  output logic [NREG-1:0] alu_r_a,
  output logic [NREG-1:0] alu_r_b,
  output logic [NREG-1:0] alu_w,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_OPND,
    S_WAIT,
    S_WB
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_MOVD = 2'd1;
  localparam logic [1:0] OP_MOVA = 2'd2;
  localparam logic [1:0] OP_ALU  = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] dst_q, dst_d;
  logic [2:0] src_a_q, src_a_d;
  logic [2:0] src_b_q, src_b_d;
  logic       bad_q, bad_d;
  logic       bad_cmd;
  logic       tmo_hit;

  function automatic logic in_rng(input logic [2:0] i);
    return int'(i) < NREG;
  endfunction

  function automatic logic [NREG-1:0] oh(input logic [2:0] i);
    logic [NREG-1:0] v;
    v = '0;
    for (int k = 0; k < NREG; k++) v[k] = (int'(i) == k);
    return v;
  endfunction

`ifdef REG_XFER_SEQ_ALU_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(ALU_TMO - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
  assign tmo_hit = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^8'(ALU_TMO);
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    bad_cmd = 1'b0;
    unique case (cmd_op)
      OP_NOP:  bad_cmd = 1'b0;
      OP_MOVD,
      OP_MOVA: bad_cmd = !in_rng(cmd_dst) || !in_rng(cmd_src_a);
      OP_ALU:  bad_cmd = !in_rng(cmd_dst) || !in_rng(cmd_src_a)
                      || !in_rng(cmd_src_b);
      default: bad_cmd = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    bad_d     = bad_q;
`ifdef REG_XFER_SEQ_ALU_TMO_EN
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
`endif
    cmd_ready = 1'b0;
    rdata     = '0;
    wdata     = '0;
    raddr     = '0;
    waddr     = '0;
    alu_r_a   = '0;
    alu_r_b   = '0;
    alu_w     = '0;
    alu_start = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          src_a_d = cmd_src_a;
          src_b_d = cmd_src_b;
          bad_d   = bad_cmd;
          state_d = (cmd_op == OP_ALU && !bad_cmd) ? S_OPND : S_XFER;
        end
      end
      S_XFER: begin
        if (!bad_q && op_q == OP_MOVD) begin
          rdata = oh(src_a_q);
          wdata = oh(dst_q);
        end
        if (!bad_q && op_q == OP_MOVA) begin
          raddr = oh(src_a_q);
          waddr = oh(dst_q);
        end
        done    = 1'b1;
        err     = bad_q;
        state_d = S_IDLE;
      end
      S_OPND: begin
        alu_r_a   = oh(src_a_q);
        alu_r_b   = oh(src_b_q);
        alu_start = 1'b1;
`ifdef REG_XFER_SEQ_ALU_TMO_EN
        cnt_d     = '0;
        tmo_d     = 1'b0;
`endif
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        alu_r_a = oh(src_a_q);
        alu_r_b = oh(src_b_q);
        if (alu_done) begin
          state_d = S_WB;
        end
`ifdef REG_XFER_SEQ_ALU_TMO_EN
        else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_WB: begin
        // A timed-out op finishes here too, but must not write back
        alu_w   = tmo_hit ? '0 : oh(dst_q);
        done    = 1'b1;
        err     = tmo_hit;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset silences every output in the same cycle it is seen
    if (rst) begin
      cmd_ready = 1'b0;
      rdata     = '0;
      wdata     = '0;
      raddr     = '0;
      waddr     = '0;
      alu_r_a   = '0;
      alu_r_b   = '0;
      alu_w     = '0;
      alu_start = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      bad_q   <= 1'b0;
`ifdef REG_XFER_SEQ_ALU_TMO_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      bad_q   <= bad_d;
`ifdef REG_XFER_SEQ_ALU_TMO_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Self-checking bench for reg_xfer_seq: per-cycle vector table plus
// hand sequences for the long ALU wait / timeout and reset recovery.
module tb_reg_xfer_seq;

  localparam int NREG = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [2:0]      cmd_dst = '0;
  logic [2:0]      cmd_src_a = '0;
  logic [2:0]      cmd_src_b = '0;
  logic [NREG-1:0] rdata, wdata, raddr, waddr;
  logic [NREG-1:0] alu_r_a, alu_r_b, alu_w;
  logic            alu_start;
  logic            alu_done = 1'b0;
  logic            busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  reg_xfer_seq #(.NREG(NREG), .ALU_TMO(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .rdata(rdata), .wdata(wdata), .raddr(raddr), .waddr(waddr),
    .alu_r_a(alu_r_a), .alu_r_b(alu_r_b), .alu_w(alu_w),
    .alu_start(alu_start), .alu_done(alu_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  op;
    logic [2:0]  d;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        ad;
    logic [32:0] exp;
  } vec_t;

  // ctl = {cmd_ready, busy, done, err, alu_start}
  localparam logic [4:0] RST = 5'b00000;
  localparam logic [4:0] IDL = 5'b10000;
  localparam logic [4:0] XF  = 5'b01100;
  localparam logic [4:0] XE  = 5'b01110;
  localparam logic [4:0] OPN = 5'b01001;
  localparam logic [4:0] BZ  = 5'b01000;

  vec_t tbl[$];

  function automatic vec_t row(
    input logic r, input logic v, input logic [1:0] op,
    input logic [2:0] d, input logic [2:0] a, input logic [2:0] b,
    input logic ad, input logic [4:0] ctl,
    input logic [3:0] rd, input logic [3:0] wd,
    input logic [3:0] ra, input logic [3:0] wa,
    input logic [3:0] aa, input logic [3:0] ab,
    input logic [3:0] aw);
    vec_t x;
    x.rst = r; x.v = v; x.op = op;
    x.d = d; x.a = a; x.b = b; x.ad = ad;
    x.exp = {ctl, rd, wd, ra, wa, aa, ab, aw};
    return x;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Bus-safety invariants, checked every cycle
  always @(negedge clk) begin
    n_cmp++;
    if (!($onehot0(rdata) && $onehot0(wdata) && $onehot0(raddr)
          && $onehot0(waddr) && $onehot0(alu_r_a)
          && $onehot0(alu_r_b) && $onehot0(alu_w)
          && (rdata & raddr) == '0 && (rdata & alu_r_a) == '0
          && (raddr & alu_r_a) == '0 && (wdata & waddr) == '0)) begin
      n_bad++;
      $display("FAIL invariant @%0t: rd=%b wd=%b ra=%b wa=%b aa=%b ab=%b aw=%b",
               $time, rdata, wdata, raddr, waddr, alu_r_a, alu_r_b, alu_w);
    end
  end

  logic [32:0] got;
  int          n;
  logic        seen;

  initial begin
    // reset, then MOVD 2->0 and MOVA 1->3
    tbl.push_back(row(1,0,0,0,0,0,0, RST, 0,0,0,0,0,0,0));
    tbl.push_back(row(1,0,0,0,0,0,0, RST, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,1,0,2,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, XF,  4'b0100,4'b0001,0,0,0,0,0));
    tbl.push_back(row(0,1,2,3,1,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, XF,  0,0,4'b0010,4'b1000,0,0,0));
    // ALU a=1 b=1 dst=3; stale alu_done in OPND must be ignored
    tbl.push_back(row(0,1,3,3,1,1,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,1, OPN, 0,0,0,0,4'b0010,4'b0010,0));
    tbl.push_back(row(0,0,0,0,0,0,0, BZ,  0,0,0,0,4'b0010,4'b0010,0));
    tbl.push_back(row(0,0,0,0,0,0,0, BZ,  0,0,0,0,4'b0010,4'b0010,0));
    tbl.push_back(row(0,0,0,0,0,0,0, BZ,  0,0,0,0,4'b0010,4'b0010,0));
    tbl.push_back(row(0,0,0,0,0,0,1, BZ,  0,0,0,0,4'b0010,4'b0010,0));
    tbl.push_back(row(0,0,0,0,0,0,0, XF,  0,0,0,0,0,0,4'b1000));
    // out-of-range dst, NOP, out-of-range ALU src_b
    tbl.push_back(row(0,1,1,5,0,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, XE,  0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,0,0,0,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, XF,  0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,3,0,0,6,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, XE,  0,0,0,0,0,0,0));
    // back-to-back with cmd_valid held high
    tbl.push_back(row(0,1,1,1,0,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,2,2,3,0,0, XF,  4'b0001,4'b0010,0,0,0,0,0));
    tbl.push_back(row(0,1,2,2,3,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,1,1,3,3,0,0, XF,  0,0,4'b1000,4'b0100,0,0,0));
    tbl.push_back(row(0,1,1,3,3,0,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, XF,  4'b1000,4'b1000,0,0,0,0,0));
    // reset mid-WAIT
    tbl.push_back(row(0,1,3,2,0,3,0, IDL, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, OPN, 0,0,0,0,4'b0001,4'b1000,0));
    tbl.push_back(row(0,0,0,0,0,0,0, BZ,  0,0,0,0,4'b0001,4'b1000,0));
    tbl.push_back(row(0,0,0,0,0,0,0, BZ,  0,0,0,0,4'b0001,4'b1000,0));
    tbl.push_back(row(1,0,0,0,0,0,0, RST, 0,0,0,0,0,0,0));
    tbl.push_back(row(1,0,0,0,0,0,0, RST, 0,0,0,0,0,0,0));
    tbl.push_back(row(1,0,0,0,0,0,0, RST, 0,0,0,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0, IDL, 0,0,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst       = tbl[i].rst;
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_dst   = tbl[i].d;
      cmd_src_a = tbl[i].a;
      cmd_src_b = tbl[i].b;
      alu_done  = tbl[i].ad;
      #1;
      got = {cmd_ready, busy, done, err, alu_start,
             rdata, wdata, raddr, waddr, alu_r_a, alu_r_b, alu_w};
      n_cmp++;
      if (got !== tbl[i].exp) begin
        n_bad++;
        $display("FAIL row %0d: got %b, expected %b", i, got, tbl[i].exp);
      end
    end

    // ALU op whose result never arrives
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_dst   = 3'd1;
    cmd_src_a = 3'd2;
    cmd_src_b = 3'd2;
    alu_done  = 1'b0;
    #1;
    chk("lw_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    #1;
    chk("lw_start", int'(alu_start), 1);
    chk("lw_opnd_a", int'(alu_r_a), 4);
    chk("lw_opnd_b", int'(alu_r_b), 4);
    @(posedge clk);
    #2;
`ifdef REG_XFER_SEQ_ALU_TMO_EN
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_err", int'(err), 1);
    chk("tmo_alu_w", int'(alu_w), 0);
`else
    seen = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (done) seen = 1'b1;
      @(posedge clk);
      #2;
    end
    chk("hang_busy", int'(busy), 1);
    chk("hang_no_done", int'(seen), 0);
`endif

    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("rst2_ready", int'(cmd_ready), 0);
    chk("rst2_opnd", int'(alu_r_a | alu_r_b), 0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("rst2_ready_after", int'(cmd_ready), 1);
    chk("rst2_busy_after", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
